// File: rtl/seq_detect_arb.sv
// Round-robin scheduler sharing one "RUN_LEN consecutive ones" detector among NCH serial requesters.
// Optional per-channel match counters are built when SEQ_DETECT_ARB_STATS_EN is defined.
module seq_detect_arb #(
  parameter int unsigned NCH       = 4,
  parameter int unsigned RUN_LEN   = 3,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NCH-1:0]                req,
  input  logic [NCH-1:0]                din,
  input  logic [NCH-1:0]                vld,
  output logic [NCH-1:0]                gnt,
  output logic                          busy,
  output logic                          match,
  output logic [$clog2(NCH)-1:0]        match_ch,
  output logic [NCH*8-1:0]              stat_cnt
);

  localparam int unsigned CW = $clog2(NCH);
  localparam int unsigned RW = $clog2(RUN_LEN + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [CW-1:0]  ptr, ptr_n, cur, cur_n, match_ch_n;
  logic [RW-1:0]  run, run_n;
  logic [7:0]     burst, burst_n;
  logic [NCH-1:0] gnt_n;
  logic           busy_n, match_n;
  logic           found, hit;
  logic [CW-1:0]  win, idx;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      cur      <= '0;
      run      <= '0;
      burst    <= '0;
      gnt      <= '0;
      busy     <= 1'b0;
      match    <= 1'b0;
      match_ch <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      cur      <= cur_n;
      run      <= run_n;
      burst    <= burst_n;
      gnt      <= gnt_n;
      busy     <= busy_n;
      match    <= match_n;
      match_ch <= match_ch_n;
    end
  end

  // Next-state, arbitration and detector update
  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    cur_n      = cur;
    run_n      = run;
    burst_n    = burst;
    gnt_n      = gnt;
    match_ch_n = match_ch;
    hit        = 1'b0;
    found      = 1'b0;
    win        = '0;
    idx        = '0;

    for (int i = 0; i < int'(NCH); i++) begin
      idx = CW'((int'(ptr) + i) % int'(NCH));
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    case (state)
      IDLE: begin
        gnt_n = '0;
        if (found) begin
          gnt_n   = NCH'(1) << win;
          cur_n   = win;
          run_n   = '0;
          burst_n = '0;
          ptr_n   = (win == CW'(NCH - 1)) ? '0 : win + CW'(1);
          state_n = SERVE;
        end
      end
      SERVE: begin
        if (!req[cur]) begin
          gnt_n   = '0;
          state_n = RELEASE;
        end else if (vld[cur]) begin
          burst_n = burst + 8'd1;
          if (din[cur]) begin
            run_n = (run == RW'(RUN_LEN)) ? run : run + RW'(1);
            hit   = (run >= RW'(RUN_LEN - 1));
          end else begin
            run_n = '0;
          end
          if (burst == 8'(MAX_BURST - 1)) begin
            gnt_n   = '0;
            state_n = RELEASE;
          end
        end
      end
      RELEASE: begin
        gnt_n   = '0;
        run_n   = '0;
        burst_n = '0;
        state_n = IDLE;
      end
      default: begin
        gnt_n   = '0;
        run_n   = '0;
        burst_n = '0;
        state_n = IDLE;
      end
    endcase

    match_n = hit;
    if (hit) match_ch_n = cur;
    busy_n = (state_n != IDLE);
  end

`ifdef SEQ_DETECT_ARB_STATS_EN
  logic [NCH-1:0][7:0] stat_q, stat_n;

  // Saturating per-channel match counters, updated alongside the match pulse
  always_comb begin
    stat_n = stat_q;
    if (hit && (stat_q[cur] != 8'hFF)) stat_n[cur] = stat_q[cur] + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stat_q <= '0;
    else        stat_q <= stat_n;
  end

  assign stat_cnt = stat_q;
`else
  assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_arb.sv
// Directed bench for seq_detect_arb (NCH=4, RUN_LEN=3, MAX_BURST=16).
module tb_seq_detect_arb;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0, din = '0, vld = '0;
  logic [3:0] gnt;
  logic       busy, match;
  logic [1:0] match_ch;
  logic [31:0] stat_cnt;

  int n_vec = 0;
  int n_err = 0;

  seq_detect_arb #(.NCH(4), .RUN_LEN(3), .MAX_BURST(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .vld(vld),
    .gnt(gnt), .busy(busy), .match(match), .match_ch(match_ch), .stat_cnt(stat_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drain;
    int n;
    req = '0; vld = '0; din = '0;
    n = 0;
    tick();
    while (busy && n < 10) begin
      tick();
      n++;
    end
    n_vec++;
    if (busy !== 1'b0) begin
      $display("FAIL drain_idle busy=%b required 0", busy);
      n_err++;
    end
  endtask

  task automatic test_reset;
    req = 4'b1111;
    rst_n = 1'b0;
    tick();
    tick();
    n_vec++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || match !== 1'b0 || match_ch !== 2'd0 || stat_cnt !== 32'd0) begin
      $display("FAIL reset_state gnt=%b busy=%b match=%b ch=%0d stat=%h required 0", gnt, busy, match, match_ch, stat_cnt);
      n_err++;
    end
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      $display("FAIL reset_first_grant gnt=%b busy=%b required 0001/1", gnt, busy);
      n_err++;
    end
    drain();
  endtask

  task automatic test_single;
    logic [6:0] bits;
    logic [6:0] exp_m;
    bits  = 7'b1111011;
    exp_m = 7'b1100000;
    req = 4'b0100; vld = 4'b0100; din = '0;
    tick();
    n_vec++;
    if (gnt !== 4'b0100) begin
      $display("FAIL single_grant gnt=%b required 0100", gnt);
      n_err++;
    end
    for (int k = 0; k < 7; k++) begin
      din = {1'b0, bits[k], 2'b00};
      tick();
      n_vec++;
      if (match !== exp_m[k] || (exp_m[k] && match_ch !== 2'd2)) begin
        $display("FAIL single_bit%0d match=%b ch=%0d required %b/2", k, match, match_ch, exp_m[k]);
        n_err++;
      end
    end
    vld = '0;
    tick();
    n_vec++;
    if (match !== 1'b0 || match_ch !== 2'd2) begin
      $display("FAIL single_idle_bit match=%b ch=%0d required 0/2", match, match_ch);
      n_err++;
    end
    drain();
    n_vec++;
`ifdef SEQ_DETECT_ARB_STATS_EN
    if (stat_cnt !== 32'h0002_0000) begin
      $display("FAIL single_stats stat=%h required 00020000", stat_cnt);
      n_err++;
    end
`else
    if (stat_cnt !== 32'd0) begin
      $display("FAIL single_stats stat=%h required 0", stat_cnt);
      n_err++;
    end
`endif
  endtask

  task automatic test_round_robin;
    int hi, gap, n;
    logic [3:0] exp_g;
    req = 4'b1111; vld = 4'b1111; din = '0;
    do_reset();
    n = 0;
    tick();
    while (gnt == 4'b0000 && n < 10) begin
      tick();
      n++;
    end
    for (int g = 0; g < 5; g++) begin
      exp_g = 4'b0001 << (g % 4);
      n_vec++;
      if (gnt !== exp_g) begin
        $display("FAIL rr_order%0d gnt=%b required %b", g, gnt, exp_g);
        n_err++;
      end
      if (g == 4) break;
      hi = 0;
      while (gnt != 4'b0000 && hi < 100) begin
        tick();
        hi++;
      end
      n_vec++;
      if (hi != 16) begin
        $display("FAIL rr_burst_len%0d cycles=%0d required 16", g, hi);
        n_err++;
      end
      gap = 0;
      while (gnt == 4'b0000 && gap < 100) begin
        tick();
        gap++;
      end
      n_vec++;
      if (gap != 2) begin
        $display("FAIL rr_gap%0d cycles=%0d required 2", g, gap);
        n_err++;
      end
    end
    drain();
  endtask

  task automatic test_burst;
    int acc, nm;
    logic dropped_ok;
    acc = 0; nm = 0; dropped_ok = 1'b0;
    req = 4'b0010; vld = 4'b0010; din = 4'b0010;
    tick();
    n_vec++;
    if (gnt !== 4'b0010) begin
      $display("FAIL burst_grant gnt=%b required 0010", gnt);
      n_err++;
    end
    for (int k = 0; k < 20; k++) begin
      if (gnt[1]) acc++;
      else req = 4'b0000;
      tick();
      if (match) begin
        nm++;
        if (match_ch !== 2'd1) begin
          $display("FAIL burst_match_ch ch=%0d required 1", match_ch);
          n_err++;
        end
      end
      if (acc == 16 && gnt[1] == 1'b0 && !dropped_ok && k == 15) dropped_ok = 1'b1;
    end
    n_vec++;
    if (acc != 16) begin
      $display("FAIL burst_accepts got=%0d required 16", acc);
      n_err++;
    end
    n_vec++;
    if (nm != 14) begin
      $display("FAIL burst_matches got=%0d required 14", nm);
      n_err++;
    end
    n_vec++;
    if (!dropped_ok) begin
      $display("FAIL burst_gnt_drop dropped_after_16th=%b required 1", dropped_ok);
      n_err++;
    end
    drain();
  endtask

  task automatic test_req_drop;
    logic [2:0] exp_m;
    exp_m = 3'b100;
    req = 4'b0001; vld = 4'b0001; din = 4'b0001;
    tick();
    n_vec++;
    if (gnt !== 4'b0001) begin
      $display("FAIL drop_grant gnt=%b required 0001", gnt);
      n_err++;
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_vec++;
      if (match !== 1'b0) begin
        $display("FAIL drop_pre%0d match=%b required 0", k, match);
        n_err++;
      end
    end
    req = 4'b0000;
    tick();
    n_vec++;
    if (match !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b1) begin
      $display("FAIL drop_release match=%b gnt=%b busy=%b required 0/0000/1", match, gnt, busy);
      n_err++;
    end
    tick();
    n_vec++;
    if (busy !== 1'b0) begin
      $display("FAIL drop_idle busy=%b required 0", busy);
      n_err++;
    end
    req = 4'b0001;
    tick();
    n_vec++;
    if (gnt !== 4'b0001) begin
      $display("FAIL drop_regrant gnt=%b required 0001", gnt);
      n_err++;
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++;
      if (match !== exp_m[k]) begin
        $display("FAIL drop_post%0d match=%b required %b", k, match, exp_m[k]);
        n_err++;
      end
    end
    drain();
  endtask

  task automatic test_reset_mid;
    req = 4'b1000; vld = 4'b1000; din = 4'b1000;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (gnt !== 4'b0000 || match !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL midreset_async gnt=%b match=%b busy=%b required 0", gnt, match, busy);
      n_err++;
    end
    tick();
    n_vec++;
    if (match !== 1'b0 || stat_cnt !== 32'd0) begin
      $display("FAIL midreset_pending match=%b stat=%h required 0", match, stat_cnt);
      n_err++;
    end
    rst_n = 1'b1;
    drain();
  endtask

  task automatic test_stats;
    int nm, n;
    req = 4'b1000; vld = 4'b1000; din = 4'b1000;
    do_reset();
    nm = 0; n = 0;
    while (nm < 300 && n < 20000) begin
      tick();
      n++;
      if (match) begin
        nm++;
        if (nm == 100) begin
          n_vec++;
`ifdef SEQ_DETECT_ARB_STATS_EN
          if (stat_cnt !== 32'h6400_0000) begin
            $display("FAIL stats_100 stat=%h required 64000000", stat_cnt);
            n_err++;
          end
`else
          if (stat_cnt !== 32'd0) begin
            $display("FAIL stats_100 stat=%h required 0", stat_cnt);
            n_err++;
          end
`endif
        end
      end
    end
    n_vec++;
    if (nm != 300) begin
      $display("FAIL stats_match_count got=%0d required 300", nm);
      n_err++;
    end
    drain();
    n_vec++;
`ifdef SEQ_DETECT_ARB_STATS_EN
    if (stat_cnt !== 32'hFF00_0000) begin
      $display("FAIL stats_saturate stat=%h required ff000000", stat_cnt);
      n_err++;
    end
`else
    if (stat_cnt !== 32'd0) begin
      $display("FAIL stats_saturate stat=%h required 0", stat_cnt);
      n_err++;
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_req_drop();
    test_reset_mid();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
